// File: rtl/envm_pkg.sv
// Shared encodings for the eNVM pattern store: field codes, FSM states,
// pattern phase and test type.
package envm_pkg;

  // cfg_field codes selecting which pattern field a cfg write targets
  localparam logic [2:0] FLD_WEIGHT1 = 3'd0;
  localparam logic [2:0] FLD_WEIGHT2 = 3'd1;
  localparam logic [2:0] FLD_ACT1    = 3'd2;
  localparam logic [2:0] FLD_ACT2    = 3'd3;
  localparam logic [2:0] FLD_PSUM1   = 3'd4;
  localparam logic [2:0] FLD_PSUM2   = 3'd5;
  localparam logic [2:0] FLD_LA_ANS  = 3'd6;
  localparam logic [2:0] FLD_CA_ANS  = 3'd7;

  // pat_phase encoding
  localparam logic PHASE_LAUNCH  = 1'b0;
  localparam logic PHASE_CAPTURE = 1'b1;

  // test_type encoding
  localparam logic TT_SA = 1'b0;
  localparam logic TT_TD = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SA_EMIT    = 3'd1,
    ST_TD_LAUNCH  = 3'd2,
    ST_TD_CAPTURE = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

endpackage

// File: rtl/envm_pattern_store_if.sv
// Pattern stream bus: valid/ready handshake plus the beat payload.
// master = pattern store side, slave = consumer side.
interface envm_pattern_store_if #(
  parameter int AW               = 5,
  parameter int WEIGHT_WIDTH     = 8,
  parameter int ACTIVATION_WIDTH = 8,
  parameter int PW               = 19
);
  logic                        pat_valid;
  logic                        pat_ready;
  logic [AW-1:0]               pat_index;
  logic                        pat_phase;
  logic [WEIGHT_WIDTH-1:0]     pat_weight;
  logic [ACTIVATION_WIDTH-1:0] pat_activation;
  logic [PW-1:0]               pat_psum;
  logic [PW-1:0]               pat_answer;

  modport master (
    output pat_valid, pat_index, pat_phase, pat_weight,
           pat_activation, pat_psum, pat_answer,
    input  pat_ready
  );

  modport slave (
    input  pat_valid, pat_index, pat_phase, pat_weight,
           pat_activation, pat_psum, pat_answer,
    output pat_ready
  );
endinterface

// File: rtl/envm_fault_map.sv
// PE fault map with row/column fault vectors and a registered popcount.
// ENVM_FAULT_ACCUM_EN defined: detections OR-accumulate (sticky until
// fault_clear/rst). Undefined: each detection overwrites the stored value.
module envm_fault_map
  import envm_pkg::*;
#(
  parameter int N = 8,
  localparam int DAW = $clog2(N),
  localparam int CW  = $clog2(N*N+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_detection_en,
  input  logic [DAW-1:0]   i_detection_addr,
  input  logic [N-1:0]     i_single_pe_detection,
  input  logic [N-1:0]     i_row_fault_detection,
  input  logic [N-1:0]     i_column_fault_detection,
  input  logic             i_fault_clear,
  output logic [N*N-1:0]   o_map,
  output logic [N-1:0]     o_row,
  output logic [N-1:0]     o_column,
  output logic [CW-1:0]    o_count
);

  function automatic logic [CW-1:0] popcount(input logic [N*N-1:0] v);
    logic [CW-1:0] acc;
    acc = '0;
    for (int k = 0; k < N*N; k++) begin
      acc = acc + {{(CW-1){1'b0}}, v[k]};
    end
    return acc;
  endfunction

  logic [N*N-1:0] r_map;
  logic [N-1:0]   r_row;
  logic [N-1:0]   r_column;
  logic [CW-1:0]  r_count;
  logic [N*N-1:0] w_map_nxt;
  logic [N-1:0]   w_row_nxt;
  logic [N-1:0]   w_column_nxt;
  logic           w_addr_ok;

  assign w_addr_ok = (int'(i_detection_addr) < N);

  // Next fault storage: clear wins, then detection merge, else hold.
  always_comb begin
    w_map_nxt    = r_map;
    w_row_nxt    = r_row;
    w_column_nxt = r_column;
    if (i_fault_clear) begin
      w_map_nxt    = '0;
      w_row_nxt    = '0;
      w_column_nxt = '0;
    end else if (i_detection_en) begin
`ifdef ENVM_FAULT_ACCUM_EN
      w_row_nxt    = r_row | i_row_fault_detection;
      w_column_nxt = r_column | i_column_fault_detection;
      if (w_addr_ok) begin
        w_map_nxt[int'(i_detection_addr)*N +: N] =
          r_map[int'(i_detection_addr)*N +: N] | i_single_pe_detection;
      end else begin
        w_map_nxt = r_map;
      end
`else
      w_row_nxt    = i_row_fault_detection;
      w_column_nxt = i_column_fault_detection;
      if (w_addr_ok) begin
        w_map_nxt[int'(i_detection_addr)*N +: N] = i_single_pe_detection;
      end else begin
        w_map_nxt = r_map;
      end
`endif
    end else begin
      w_map_nxt    = r_map;
    end
  end

  // Fault storage and count; count follows the stored map one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_map    <= '0;
      r_row    <= '0;
      r_column <= '0;
      r_count  <= '0;
    end else begin
      r_map    <= w_map_nxt;
      r_row    <= w_row_nxt;
      r_column <= w_column_nxt;
      r_count  <= popcount(r_map);
    end
  end

  assign o_map    = r_map;
  assign o_row    = r_row;
  assign o_column = r_column;
  assign o_count  = r_count;

endmodule

// File: rtl/envm_pattern_store.sv
// eNVM-backed test pattern store: holds stuck-at (SA) and transition-delay
// (TD) patterns, streams them over a valid/ready bus, and tracks a PE fault
// map. Pattern memory survives rst. Fault merge mode: ENVM_FAULT_ACCUM_EN.
module envm_pattern_store
  import envm_pkg::*;
#(
  parameter int SYSTOLIC_SIZE     = 8,
  parameter int WEIGHT_WIDTH      = 8,
  parameter int ACTIVATION_WIDTH  = 8,
  parameter int PARTIAL_SUM_WIDTH = WEIGHT_WIDTH + ACTIVATION_WIDTH + $clog2(SYSTOLIC_SIZE),
  parameter int SA_DEPTH          = 12,
  parameter int TD_DEPTH          = 18,
  localparam int AW  = $clog2((SA_DEPTH > TD_DEPTH) ? SA_DEPTH : TD_DEPTH),
  localparam int N   = SYSTOLIC_SIZE,
  localparam int PW  = PARTIAL_SUM_WIDTH,
  localparam int DAW = $clog2(SYSTOLIC_SIZE),
  localparam int CW  = $clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE+1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_cfg_we,
  input  logic                 i_cfg_test_type,
  input  logic [2:0]           i_cfg_field,
  input  logic [AW-1:0]        i_cfg_addr,
  input  logic [PW-1:0]        i_cfg_wdata,
  input  logic                 i_start,
  input  logic                 i_test_type,
  output logic                 o_busy,
  output logic                 o_done,
  envm_pattern_store_if.master pat_if,
  input  logic                 i_detection_en,
  input  logic [DAW-1:0]       i_detection_addr,
  input  logic [N-1:0]         i_single_pe_detection,
  input  logic [N-1:0]         i_row_fault_detection,
  input  logic [N-1:0]         i_column_fault_detection,
  input  logic                 i_fault_clear,
  output logic [N*N-1:0]       o_envm_faulty_patterns_flat,
  output logic [N-1:0]         o_faulty_row,
  output logic [N-1:0]         o_faulty_column,
  output logic [CW-1:0]        o_fault_pe_count
);

  localparam int            MEM_DEPTH  = 1 << AW;
  localparam logic [AW:0]   SA_DEPTH_W = (AW+1)'(SA_DEPTH);
  localparam logic [AW:0]   TD_DEPTH_W = (AW+1)'(TD_DEPTH);
  localparam logic [AW-1:0] SA_LAST    = AW'(SA_DEPTH - 1);
  localparam logic [AW-1:0] TD_LAST    = AW'(TD_DEPTH - 1);

  // SA slots indexed by field code [2:1]: weight1, act1, psum1, launch answer
  logic [PW-1:0] r_sa_mem [0:3][0:MEM_DEPTH-1];
  logic [PW-1:0] r_td_mem [0:7][0:MEM_DEPTH-1];

  state_t                      r_state, w_state_nxt;
  logic [AW-1:0]               r_index, w_index_nxt;
  logic                        r_pat_valid, r_pat_phase, r_busy, r_done;
  logic [WEIGHT_WIDTH-1:0]     r_weight, w_weight;
  logic [ACTIVATION_WIDTH-1:0] r_act, w_act;
  logic [PW-1:0]               r_psum, w_psum, r_answer, w_answer;
  logic                        w_hs, w_load, w_emit_nxt;

  assign w_hs       = r_pat_valid & pat_if.pat_ready;
  assign w_load     = ((r_state == ST_IDLE) & i_start) | w_hs;
  assign w_emit_nxt = (w_state_nxt == ST_SA_EMIT) || (w_state_nxt == ST_TD_LAUNCH) ||
                      (w_state_nxt == ST_TD_CAPTURE);

  // Pattern memory write port, open only while idle; no reset (non-volatile).
  always_ff @(posedge clk) begin
    if (i_cfg_we && !r_busy) begin
      if (i_cfg_test_type == TT_SA) begin
        if (!i_cfg_field[0] && ({1'b0, i_cfg_addr} < SA_DEPTH_W)) begin
          r_sa_mem[i_cfg_field[2:1]][i_cfg_addr] <= i_cfg_wdata;
        end
      end else if ({1'b0, i_cfg_addr} < TD_DEPTH_W) begin
        r_td_mem[i_cfg_field][i_cfg_addr] <= i_cfg_wdata;
      end
    end
  end

  // Next state and next pattern index.
  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt = (i_test_type == TT_TD) ? ST_TD_LAUNCH : ST_SA_EMIT;
          w_index_nxt = '0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SA_EMIT: begin
        if (w_hs && (r_index == SA_LAST)) begin
          w_state_nxt = ST_DONE;
        end else if (w_hs) begin
          w_index_nxt = r_index + {{(AW-1){1'b0}}, 1'b1};
        end else begin
          w_state_nxt = ST_SA_EMIT;
        end
      end
      ST_TD_LAUNCH: begin
        if (w_hs) begin
          w_state_nxt = ST_TD_CAPTURE;
        end else begin
          w_state_nxt = ST_TD_LAUNCH;
        end
      end
      ST_TD_CAPTURE: begin
        if (w_hs && (r_index == TD_LAST)) begin
          w_state_nxt = ST_DONE;
        end else if (w_hs) begin
          w_state_nxt = ST_TD_LAUNCH;
          w_index_nxt = r_index + {{(AW-1){1'b0}}, 1'b1};
        end else begin
          w_state_nxt = ST_TD_CAPTURE;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Beat payload for the upcoming state/index.
  always_comb begin
    w_weight = '0;
    w_act    = '0;
    w_psum   = '0;
    w_answer = '0;
    case (w_state_nxt)
      ST_SA_EMIT: begin
        w_weight = r_sa_mem[0][w_index_nxt][WEIGHT_WIDTH-1:0];
        w_act    = r_sa_mem[1][w_index_nxt][ACTIVATION_WIDTH-1:0];
        w_psum   = r_sa_mem[2][w_index_nxt];
        w_answer = r_sa_mem[3][w_index_nxt];
      end
      ST_TD_LAUNCH: begin
        w_weight = r_td_mem[FLD_WEIGHT2][w_index_nxt][WEIGHT_WIDTH-1:0];
        w_act    = r_td_mem[FLD_ACT2][w_index_nxt][ACTIVATION_WIDTH-1:0];
        w_psum   = r_td_mem[FLD_PSUM2][w_index_nxt];
        w_answer = r_td_mem[FLD_LA_ANS][w_index_nxt];
      end
      ST_TD_CAPTURE: begin
        w_weight = r_td_mem[FLD_WEIGHT2][w_index_nxt][WEIGHT_WIDTH-1:0];
        w_act    = r_td_mem[FLD_ACT1][w_index_nxt][ACTIVATION_WIDTH-1:0];
        w_psum   = r_td_mem[FLD_PSUM1][w_index_nxt];
        w_answer = r_td_mem[FLD_CA_ANS][w_index_nxt];
      end
      default: begin
        w_weight = '0;
      end
    endcase
  end

  // State and output registers; payload only reloads on start or handshake,
  // which keeps it frozen while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_index     <= '0;
      r_pat_valid <= 1'b0;
      r_pat_phase <= PHASE_LAUNCH;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_weight    <= '0;
      r_act       <= '0;
      r_psum      <= '0;
      r_answer    <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_index     <= w_index_nxt;
      r_pat_valid <= w_emit_nxt;
      r_pat_phase <= (w_state_nxt == ST_TD_CAPTURE) ? PHASE_CAPTURE : PHASE_LAUNCH;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_done      <= (w_state_nxt == ST_DONE);
      if (w_load) begin
        r_weight <= w_weight;
        r_act    <= w_act;
        r_psum   <= w_psum;
        r_answer <= w_answer;
      end
    end
  end

  assign pat_if.pat_valid      = r_pat_valid;
  assign pat_if.pat_index      = r_index;
  assign pat_if.pat_phase      = r_pat_phase;
  assign pat_if.pat_weight     = r_weight;
  assign pat_if.pat_activation = r_act;
  assign pat_if.pat_psum       = r_psum;
  assign pat_if.pat_answer     = r_answer;
  assign o_busy                = r_busy;
  assign o_done                = r_done;

  envm_fault_map #(.N(N)) u_fault_map (
    .clk                      (clk),
    .rst                      (rst),
    .i_detection_en           (i_detection_en),
    .i_detection_addr         (i_detection_addr),
    .i_single_pe_detection    (i_single_pe_detection),
    .i_row_fault_detection    (i_row_fault_detection),
    .i_column_fault_detection (i_column_fault_detection),
    .i_fault_clear            (i_fault_clear),
    .o_map                    (o_envm_faulty_patterns_flat),
    .o_row                    (o_faulty_row),
    .o_column                 (o_faulty_column),
    .o_count                  (o_fault_pe_count)
  );

endmodule

// File: tb/tb_envm_pattern_store.sv
// Directed bench for envm_pattern_store: fault-map vector table plus
// hand-written SA, TD-backpressure, reset-abort and busy-ignore sequences.
module tb_envm_pattern_store;
  import envm_pkg::*;

  localparam int N = 8, WW = 8, ACTW = 8, PW = 19, AW = 5, CW = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, cfg_we, cfg_tt, start, test_type;
  logic [2:0]      cfg_field;
  logic [AW-1:0]   cfg_addr;
  logic [PW-1:0]   cfg_wdata;
  logic            busy, done;
  logic            det_en, fclr;
  logic [2:0]      det_addr;
  logic [N-1:0]    pe_det, row_det, col_det, frow, fcol;
  logic [N*N-1:0]  fmap;
  logic [CW-1:0]   fcnt;

  envm_pattern_store_if #(.AW(AW), .WEIGHT_WIDTH(WW), .ACTIVATION_WIDTH(ACTW), .PW(PW)) pif ();

  envm_pattern_store dut (
    .clk(clk), .rst(rst),
    .i_cfg_we(cfg_we), .i_cfg_test_type(cfg_tt), .i_cfg_field(cfg_field),
    .i_cfg_addr(cfg_addr), .i_cfg_wdata(cfg_wdata),
    .i_start(start), .i_test_type(test_type), .o_busy(busy), .o_done(done),
    .pat_if(pif),
    .i_detection_en(det_en), .i_detection_addr(det_addr),
    .i_single_pe_detection(pe_det), .i_row_fault_detection(row_det),
    .i_column_fault_detection(col_det), .i_fault_clear(fclr),
    .o_envm_faulty_patterns_flat(fmap), .o_faulty_row(frow),
    .o_faulty_column(fcol), .o_fault_pe_count(fcnt)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic           en;
    logic           clr;
    logic [2:0]     addr;
    logic [N-1:0]   pe;
    logic [N-1:0]   rv;
    logic [N-1:0]   cv;
    logic [63:0]    exp_map;
    logic [N-1:0]   exp_row;
    logic [N-1:0]   exp_col;
    logic [CW-1:0]  exp_cnt;
  } fvec_t;

  fvec_t fv [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic tt, input logic [2:0] f, input logic [AW-1:0] a,
                           input logic [PW-1:0] d);
    cfg_we = 1'b1; cfg_tt = tt; cfg_field = f; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask

  function automatic logic [PW-1:0] tdv(input int f, input int i);
    return PW'(f * 1000 + i);
  endfunction

  task automatic sa_beat(input int k);
    check($sformatf("sa_valid[%0d]", k), 64'(pif.pat_valid), 64'd1);
    check($sformatf("sa_index[%0d]", k), 64'(pif.pat_index), 64'(k));
    check($sformatf("sa_phase[%0d]", k), 64'(pif.pat_phase), 64'd0);
    check($sformatf("sa_weight[%0d]", k), 64'(pif.pat_weight), 64'(k));
    check($sformatf("sa_act[%0d]", k), 64'(pif.pat_activation), 64'(k + 50));
    check($sformatf("sa_psum[%0d]", k), 64'(pif.pat_psum), 64'(k + 200));
    check($sformatf("sa_answer[%0d]", k), 64'(pif.pat_answer), 64'(k + 100));
    check($sformatf("sa_busy[%0d]", k), 64'(busy), 64'd1);
    check($sformatf("sa_done[%0d]", k), 64'(done), 64'd0);
  endtask

  initial begin
    int beats, cyc, ei, ep;
    logic [PW-1:0] tw, ta, tp, tn;

    // fault vectors: map/row/col show this vector's effect, count lags one cycle
    fv[0] = '{1'b1, 1'b0, 3'd3, 8'h81, 8'h01, 8'h02, 64'h00000000_81000000, 8'h01, 8'h02, 7'd0};
`ifdef ENVM_FAULT_ACCUM_EN
    fv[1] = '{1'b1, 1'b0, 3'd3, 8'h10, 8'h04, 8'h08, 64'h00000000_91000000, 8'h05, 8'h0A, 7'd2};
    fv[2] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 64'h00000000_91000000, 8'h05, 8'h0A, 7'd3};
    fv[3] = '{1'b1, 1'b0, 3'd0, 8'hFF, 8'h80, 8'h40, 64'h00000000_910000FF, 8'h85, 8'h4A, 7'd3};
    fv[4] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 64'h00000000_910000FF, 8'h85, 8'h4A, 7'd11};
    fv[5] = '{1'b1, 1'b1, 3'd5, 8'hFF, 8'hFF, 8'hFF, 64'h0, 8'h00, 8'h00, 7'd11};
`else
    fv[1] = '{1'b1, 1'b0, 3'd3, 8'h10, 8'h04, 8'h08, 64'h00000000_10000000, 8'h04, 8'h08, 7'd2};
    fv[2] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 64'h00000000_10000000, 8'h04, 8'h08, 7'd1};
    fv[3] = '{1'b1, 1'b0, 3'd0, 8'hFF, 8'h80, 8'h40, 64'h00000000_100000FF, 8'h80, 8'h40, 7'd1};
    fv[4] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 64'h00000000_100000FF, 8'h80, 8'h40, 7'd9};
    fv[5] = '{1'b1, 1'b1, 3'd5, 8'hFF, 8'hFF, 8'hFF, 64'h0, 8'h00, 8'h00, 7'd9};
`endif
    fv[6] = '{1'b0, 1'b0, 3'd0, 8'h00, 8'h00, 8'h00, 64'h0, 8'h00, 8'h00, 7'd0};

    rst = 1'b1; cfg_we = 1'b0; cfg_tt = 1'b0; cfg_field = 3'd0; cfg_addr = '0;
    cfg_wdata = '0; start = 1'b0; test_type = 1'b0; pif.pat_ready = 1'b0;
    det_en = 1'b0; fclr = 1'b0; det_addr = 3'd0; pe_det = '0; row_det = '0; col_det = '0;
    tick(); tick();

    // reset state
    check("rst_valid", 64'(pif.pat_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_index", 64'(pif.pat_index), 64'd0);
    check("rst_phase", 64'(pif.pat_phase), 64'd0);
    check("rst_weight", 64'(pif.pat_weight), 64'd0);
    check("rst_answer", 64'(pif.pat_answer), 64'd0);
    check("rst_map", 64'(fmap), 64'd0);
    check("rst_count", 64'(fcnt), 64'd0);
    rst = 1'b0;
    tick();

    // fault map table
    for (int v = 0; v < 7; v++) begin
      det_en = fv[v].en; fclr = fv[v].clr; det_addr = fv[v].addr;
      pe_det = fv[v].pe; row_det = fv[v].rv; col_det = fv[v].cv;
      tick();
      check($sformatf("fmap[%0d]", v), 64'(fmap), fv[v].exp_map);
      check($sformatf("frow[%0d]", v), 64'(frow), 64'(fv[v].exp_row));
      check($sformatf("fcol[%0d]", v), 64'(fcol), 64'(fv[v].exp_col));
      check($sformatf("fcnt[%0d]", v), 64'(fcnt), 64'(fv[v].exp_cnt));
    end
    det_en = 1'b0; fclr = 1'b0;

    // load patterns, plus writes that must be dropped
    for (int i = 0; i < 12; i++) begin
      cfg_write(TT_SA, FLD_WEIGHT1, AW'(i), PW'(i));
      cfg_write(TT_SA, FLD_ACT1,    AW'(i), PW'(i + 50));
      cfg_write(TT_SA, FLD_PSUM1,   AW'(i), PW'(i + 200));
      cfg_write(TT_SA, FLD_LA_ANS,  AW'(i), PW'(i + 100));
    end
    cfg_write(TT_SA, FLD_WEIGHT2, AW'(0), PW'(999));
    cfg_write(TT_SA, FLD_ACT2,    AW'(0), PW'(999));
    cfg_write(TT_SA, FLD_WEIGHT1, AW'(12), PW'(999));
    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < 18; i++) begin
        cfg_write(TT_TD, 3'(f), AW'(i), tdv(f, i));
      end
    end

    // SA run, with cfg write and start pulsed mid-run
    pif.pat_ready = 1'b1; test_type = TT_SA; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      sa_beat(k);
      if (k == 3) begin
        cfg_we = 1'b1; cfg_tt = TT_SA; cfg_field = FLD_WEIGHT1; cfg_addr = AW'(5);
        cfg_wdata = PW'(77); start = 1'b1; test_type = TT_TD;
      end else begin
        cfg_we = 1'b0; start = 1'b0; test_type = TT_SA;
      end
      tick();
    end
    check("sa_end_valid", 64'(pif.pat_valid), 64'd0);
    check("sa_end_done", 64'(done), 64'd1);
    check("sa_end_busy", 64'(busy), 64'd1);
    tick();
    check("sa_idle_done", 64'(done), 64'd0);
    check("sa_idle_busy", 64'(busy), 64'd0);

    // TD run with 50% backpressure
    pif.pat_ready = 1'b0; test_type = TT_TD; start = 1'b1;
    tick();
    start = 1'b0;
    beats = 0; cyc = 0; ei = 0; ep = 0;
    while (beats < 36 && cyc < 200) begin
      pif.pat_ready = ((cyc % 2) == 1);
      tw = tdv(1, ei);
      ta = (ep == 1) ? tdv(2, ei) : tdv(3, ei);
      tp = (ep == 1) ? tdv(4, ei) : tdv(5, ei);
      tn = (ep == 1) ? tdv(7, ei) : tdv(6, ei);
      check($sformatf("td_valid[%0d]", cyc), 64'(pif.pat_valid), 64'd1);
      check($sformatf("td_index[%0d]", cyc), 64'(pif.pat_index), 64'(ei));
      check($sformatf("td_phase[%0d]", cyc), 64'(pif.pat_phase), 64'(ep));
      check($sformatf("td_weight[%0d]", cyc), 64'(pif.pat_weight), 64'(tw[WW-1:0]));
      check($sformatf("td_act[%0d]", cyc), 64'(pif.pat_activation), 64'(ta[ACTW-1:0]));
      check($sformatf("td_psum[%0d]", cyc), 64'(pif.pat_psum), 64'(tp));
      check($sformatf("td_answer[%0d]", cyc), 64'(pif.pat_answer), 64'(tn));
      if (pif.pat_ready) begin
        beats++;
        if (ep == 1) begin ep = 0; ei++; end
        else ep = 1;
      end
      tick();
      cyc++;
    end
    check("td_beats", 64'(beats), 64'd36);
    check("td_end_valid", 64'(pif.pat_valid), 64'd0);
    check("td_end_done", 64'(done), 64'd1);
    tick();
    check("td_idle_busy", 64'(busy), 64'd0);

    // reset mid SA run at beat 5
    pif.pat_ready = 1'b1; test_type = TT_SA; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("abort_pre_index", 64'(pif.pat_index), 64'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_valid", 64'(pif.pat_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_index", 64'(pif.pat_index), 64'd0);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("abort_done[%0d]", k), 64'(done), 64'd0);
      tick();
    end

    // restart: patterns intact; detection accepted while busy
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      sa_beat(k);
      if (k == 2) begin
        det_en = 1'b1; det_addr = 3'd1; pe_det = 8'h0F; row_det = '0; col_det = '0;
      end else begin
        det_en = 1'b0;
      end
      tick();
    end
    det_en = 1'b0;
    check("rerun_done", 64'(done), 64'd1);
    check("busy_detect_map", 64'(fmap), 64'h00000000_00000F00);
    tick();
    check("rerun_idle_busy", 64'(busy), 64'd0);
    check("busy_detect_cnt", 64'(fcnt), 64'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/envm_pattern_store.md
ENVM_PATTERN_STORE -- requirements
Module: envm_pattern_store

Interface
REQ-001 SHALL have parameter SYSTOLIC_SIZE, 8, array dimension N.
REQ-002 SHALL have parameter WEIGHT_WIDTH, 8, weight field width.
REQ-003 SHALL have parameter ACTIVATION_WIDTH, 8, activation field width.
REQ-004 SHALL have parameter PARTIAL_SUM_WIDTH, WEIGHT_WIDTH+ACTIVATION_WIDTH+clog2(N), psum/answer width (PW).
REQ-005 SHALL have parameters SA_DEPTH, 12, and TD_DEPTH, 18, pattern counts; AW = clog2(max(SA_DEPTH,TD_DEPTH)).
REQ-006 SHALL have ports: clk in 1, clock; rst in 1, synchronous active-high reset.
REQ-007 SHALL have cfg port: cfg_we in 1; cfg_test_type in 1 (0 SA, 1 TD); cfg_field in 3 (pattern field code); cfg_addr in AW; cfg_wdata in PW, LSB-aligned.
REQ-008 SHALL have run control: start in 1; test_type in 1; busy out 1; done out 1, one-cycle pulse.
REQ-009 SHALL have pattern stream: pat_valid out 1; pat_ready in 1; pat_index out AW; pat_phase out 1 (0 launch, 1 capture); pat_weight out WEIGHT_WIDTH; pat_activation out ACTIVATION_WIDTH; pat_psum out PW; pat_answer out PW.
REQ-010 SHALL have fault inputs: detection_en in 1; detection_addr in clog2(N); single_pe_detection in N; row_fault_detection in N; column_fault_detection in N; fault_clear in 1.
REQ-011 SHALL have fault outputs: envm_faulty_patterns_flat out N*N (row i at [i*N +: N]); faulty_row out N; faulty_column out N; fault_pe_count out clog2(N*N+1).

Function
REQ-012 SHALL store per-type fields: codes 0 weight1, 1 weight2, 2 act1, 3 act2, 4 psum1, 5 psum2, 6 launch answer, 7 capture answer; SA uses codes 0,2,4,6 only.
REQ-013 SHALL write a cfg entry on cfg_we only while busy=0; writes while busy, to unused SA codes, or cfg_addr >= type depth SHALL be ignored.
REQ-014 SHALL use FSM IDLE -> SA_EMIT or TD_LAUNCH on start in IDLE; start while busy ignored.
REQ-015 SHALL assert pat_valid, pat_index=0 the cycle after start; busy=1 from that cycle until DONE exits.
REQ-016 SHALL hold all pat_* outputs stable while pat_valid=1 and pat_ready=0.
REQ-017 SA_EMIT SHALL emit weight1, act1, psum1, launch answer at pat_index, phase 0; handshake advances index.
REQ-018 TD SHALL emit two beats per index: TD_LAUNCH (phase 0: weight2, act2, psum2, launch answer) then TD_CAPTURE (phase 1: weight2, act1, psum1, capture answer); capture handshake advances index.
REQ-019 Handshake on last beat (index depth-1) SHALL enter DONE: pat_valid=0, done=1 one cycle, then IDLE, busy=0.
REQ-020 detection_en SHALL update faulty_row/faulty_column with the inputs and row detection_addr with single_pe_detection (merge per REQ-028); detection_addr >= N ignored.
REQ-021 fault_clear SHALL zero all fault storage next cycle and has priority over simultaneous detection_en.
REQ-022 fault_pe_count SHALL equal popcount of envm_faulty_patterns_flat, registered, lagging storage by one cycle.
REQ-023 Fault storage SHALL be independent of FSM state; detection accepted while busy.

Reset
REQ-024 rst SHALL force IDLE; pat_valid, busy, done, pat_index, pat_phase = 0; pat data outputs = 0.
REQ-025 rst SHALL clear fault map, faulty_row, faulty_column, fault_pe_count to 0.
REQ-026 rst SHALL NOT clear pattern storage (non-volatile model); reset mid-run aborts without done.

Configuration
REQ-027 Macro ENVM_FAULT_ACCUM_EN SHALL select fault merge mode.
REQ-028 Defined: row/column/PE storage OR-accumulates (sticky until fault_clear/rst); undefined: detection overwrites.

Structure
REQ-029 Package envm_pkg SHALL hold field codes, FSM state enum, phase encoding, test_type encoding.
REQ-030 Fault map, merge logic and popcount SHALL be sub-module envm_fault_map; pattern memory and FSM in top.

Verification
REQ-031 SA: load 12 patterns weight=idx, answer=idx+100; start, ready=1 -> 12 beats idx 0..11, answer 100..111, done on cycle 13.
REQ-032 TD backpressure: TD_DEPTH=18, ready toggling 50% -> 36 beats, phases alternate 0/1, data stable while stalled, no index skipped.
REQ-033 Faults: detection_en addr=3 PE=8'h81 then addr=3 PE=8'h10 -> row 3 = 8'h91 with macro, 8'h10 without; count 3 or 1.
REQ-034 Simultaneous fault_clear+detection_en -> map all zero, count 0 next cycle+1.
REQ-035 rst at beat 5 of SA run -> pat_valid=0, busy=0, no done; restart emits index 0 with pre-reset patterns intact.
REQ-036 cfg_we while busy and start while busy -> ignored; emitted data unchanged, run length unchanged.
